// File: rtl/sram_rr_arbiter_pkg.sv
// Shared constants and types for the four-port SRAM arbiter.
// One SRAM geometry for the whole slice: a word address, a data word and a per-port latch record.
package sram_arb_pkg;

   localparam int N_PORTS = 4;
   localparam int IDX_W   = 2;
   localparam int ADDR_W  = 20;
   localparam int DATA_W  = 16;
   localparam int PERF_W  = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   typedef logic [N_PORTS-1:0][ADDR_W-1:0] addr_arr_t;
   typedef logic [N_PORTS-1:0][DATA_W-1:0] data_arr_t;

   // Everything about the granted request that must survive until DONE.
   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } acc_t;

   function automatic logic [N_PORTS-1:0] port_onehot(input logic [IDX_W-1:0] idx);
      logic [N_PORTS-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
      return (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
   endfunction

endpackage

// File: rtl/sram_rr_arbiter_if.sv
// CPU-side request/completion bundle for the four arbiter ports.
// master = CPU cluster, slave = arbiter; req/write/addr/wdata held until the port's ready pulse.
interface sram_rr_arbiter_if;
   import sram_arb_pkg::*;

   logic [N_PORTS-1:0] cpu_req;
   logic [N_PORTS-1:0] cpu_write;
   addr_arr_t          cpu_addr;
   data_arr_t          cpu_wdata;
   logic [N_PORTS-1:0] cpu_ready;
   logic [DATA_W-1:0]  cpu_rdata;

   modport master (
      output cpu_req,
      output cpu_write,
      output cpu_addr,
      output cpu_wdata,
      input  cpu_ready,
      input  cpu_rdata
   );

   modport slave (
      input  cpu_req,
      input  cpu_write,
      input  cpu_addr,
      input  cpu_wdata,
      output cpu_ready,
      output cpu_rdata
   );

endinterface

// File: rtl/sram_rr_arbiter_rr_pick4.sv
// Combinational round-robin pick: first unmasked requester at or after ptr, wrapping 3->0.
// Zero latency; valid=0 when no eligible request.
module rr_pick4
   import sram_arb_pkg::*;
(
   input  logic [N_PORTS-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   input  logic [N_PORTS-1:0] mask,
   output logic               valid,
   output logic [IDX_W-1:0]   winner
);

   logic [N_PORTS-1:0] elig;

   assign elig = req & ~mask;

   // Scan from the farthest offset down so the nearest eligible port is written last.
   always_comb begin
      valid  = 1'b0;
      winner = ptr;
      for (int i = N_PORTS - 1; i >= 0; i--) begin
         if (elig[ptr + IDX_W'(i)]) begin
            valid  = 1'b1;
            winner = ptr + IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Four-port round-robin arbiter for one async SRAM; ready pulses WAIT_CYCLES+2 cycles after req is sampled.
// Requests wait (held high) while another port owns the SRAM; optional counters under SRAM_ARB_PERF_EN.
module sram_rr_arbiter
   import sram_arb_pkg::*;
#(
   parameter int WAIT_CYCLES = 1
) (
   input  logic              Clk,
   input  logic              Reset,
   sram_rr_arbiter_if.slave  cpu,
   output logic [ADDR_W-1:0] ADDR,
   output logic [DATA_W-1:0] Data_out,
   input  logic [DATA_W-1:0] Data_in,
   output logic              data_oe,
   output logic              CE,
   output logic              UB,
   output logic              LB,
   output logic              OE,
   output logic              WE
`ifdef SRAM_ARB_PERF_EN
   ,
   output logic [N_PORTS-1:0][PERF_W-1:0] grant_cnt,
   output logic [PERF_W-1:0]              conflict_cnt
`endif
);

   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   winner_q, winner_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   acc_t               acc_q, acc_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic [N_PORTS-1:0] ready_q, ready_d;
   logic               ce_q, ce_d;
   logic               bs_q, bs_d;
   logic               oe_q, oe_d;
   logic               we_q, we_d;
   logic               doe_q, doe_d;

   logic [N_PORTS-1:0] pick_mask;
   logic               pick_vld;
   logic [IDX_W-1:0]   pick_idx;

   // The port just finishing in DONE is excluded so a held req cannot win twice in a row.
   assign pick_mask = (state_q == DONE) ? port_onehot(winner_q) : '0;

   rr_pick4 u_pick (
      .req    (cpu.cpu_req),
      .ptr    (ptr_q),
      .mask   (pick_mask),
      .valid  (pick_vld),
      .winner (pick_idx)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      winner_d = winner_q;
      ptr_d    = ptr_q;
      acc_d    = acc_q;
      rdata_d  = rdata_q;

      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (pick_vld) begin
               state_d  = SETUP;
               winner_d = pick_idx;
               acc_d    = '{write: cpu.cpu_write[pick_idx],
                            addr:  cpu.cpu_addr[pick_idx],
                            wdata: cpu.cpu_wdata[pick_idx]};
            end
         end
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               state_d = DONE;
               ptr_d   = winner_q + IDX_W'(1);
               if (!acc_q.write)
                  rdata_d = Data_in;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Strobes are registered from the next state so the SRAM pins never see decode glitches.
      ce_d    = 1'b1;
      bs_d    = 1'b1;
      oe_d    = 1'b1;
      we_d    = 1'b1;
      doe_d   = 1'b0;
      ready_d = '0;
      case (state_d)
         SETUP: begin
            ce_d  = 1'b0;
            bs_d  = 1'b0;
            oe_d  = acc_d.write;
            doe_d = acc_d.write;
         end
         ACCESS: begin
            ce_d  = 1'b0;
            bs_d  = 1'b0;
            oe_d  = acc_d.write;
            we_d  = ~acc_d.write;
            doe_d = acc_d.write;
         end
         DONE: begin
            ce_d    = 1'b0;
            bs_d    = 1'b0;
            doe_d   = acc_d.write;
            ready_d = port_onehot(winner_d);
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         winner_q <= '0;
         ptr_q    <= '0;
         acc_q    <= '0;
         rdata_q  <= '0;
         ready_q  <= '0;
         ce_q     <= 1'b1;
         bs_q     <= 1'b1;
         oe_q     <= 1'b1;
         we_q     <= 1'b1;
         doe_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         winner_q <= winner_d;
         ptr_q    <= ptr_d;
         acc_q    <= acc_d;
         rdata_q  <= rdata_d;
         ready_q  <= ready_d;
         ce_q     <= ce_d;
         bs_q     <= bs_d;
         oe_q     <= oe_d;
         we_q     <= we_d;
         doe_q    <= doe_d;
      end
   end

   assign ADDR          = acc_q.addr;
   assign Data_out      = acc_q.wdata;
   assign data_oe       = doe_q;
   assign CE            = ce_q;
   assign UB            = bs_q;
   assign LB            = bs_q;
   assign OE            = oe_q;
   assign WE            = we_q;
   assign cpu.cpu_ready = ready_q;
   assign cpu.cpu_rdata = rdata_q;

`ifdef SRAM_ARB_PERF_EN
   logic [N_PORTS-1:0][PERF_W-1:0] grant_q;
   logic [PERF_W-1:0]              conflict_q;
   logic [N_PORTS-1:0]             elig;
   logic                           arb_now;

   // Contention is judged on the requests actually competing, i.e. after masking the finisher.
   assign elig    = cpu.cpu_req & ~pick_mask;
   assign arb_now = (state_q == IDLE) || (state_q == DONE);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         grant_q    <= '0;
         conflict_q <= '0;
      end else begin
         if (state_q == DONE)
            grant_q[winner_q] <= sat_inc(grant_q[winner_q]);
         if (arb_now && ($countones(elig) >= 2))
            conflict_q <= sat_inc(conflict_q);
      end
   end

   assign grant_cnt    = grant_q;
   assign conflict_cnt = conflict_q;
`endif

   a_we_oe_excl : assert property (@(posedge Clk) disable iff (Reset) !(!WE && !OE));
   a_doe_oe     : assert property (@(posedge Clk) disable iff (Reset) data_oe |-> OE);

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: directed scenarios plus random rounds against a transaction-level model.
// SRAM is modelled behaviourally; build with SRAM_ARB_PERF_EN to also cover the counters.
module tb_sram_rr_arbiter;

   localparam int W = 1;
   localparam int P = W + 2;

   logic        Clk;
   logic        Reset;
   logic [19:0] ADDR;
   logic [15:0] Data_out;
   logic [15:0] Data_in;
   logic        data_oe, CE, UB, LB, OE, WE;
`ifdef SRAM_ARB_PERF_EN
   logic [3:0][15:0] grant_cnt;
   logic [15:0]      conflict_cnt;
`endif

   sram_rr_arbiter_if cpu_if();

   sram_rr_arbiter #(.WAIT_CYCLES(W)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .cpu      (cpu_if),
      .ADDR     (ADDR),
      .Data_out (Data_out),
      .Data_in  (Data_in),
      .data_oe  (data_oe),
      .CE       (CE),
      .UB       (UB),
      .LB       (LB),
      .OE       (OE),
      .WE       (WE)
`ifdef SRAM_ARB_PERF_EN
      ,
      .grant_cnt    (grant_cnt),
      .conflict_cnt (conflict_cnt)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Behavioural async SRAM: write while CE/WE low, drive read data while CE/OE low.
   logic [15:0] mem [int];
   always @(negedge Clk) begin
      if (!CE && !WE)
         mem[int'(ADDR)] = Data_out;
      if (!CE && !OE)
         Data_in = mem.exists(int'(ADDR)) ? mem[int'(ADDR)] : 16'h0000;
      else
         Data_in = 16'hDEAD;
   end

   int          n_vec = 0;
   int          n_err = 0;
   int          ptr_m = 0;
   logic [15:0] exp_rdata = 16'h0;
   logic [15:0] ref_mem [int];
   logic        t_write [4];
   logic [19:0] t_addr  [4];
   logic [15:0] t_wdata [4];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [15:0] ref_rd(input logic [19:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
   endfunction

   function automatic logic [5:0] strobes();
      return {CE, UB, LB, OE, WE, data_oe};
   endfunction

   task automatic do_reset();
      Reset = 1'b1;
      cpu_if.cpu_req = '0;
      step();
      check("rst_strobes", 64'(strobes()), 64'(6'b111110));
      check("rst_addr", 64'(ADDR), 64'h0);
      check("rst_dout", 64'(Data_out), 64'h0);
      check("rst_ready", 64'(cpu_if.cpu_ready), 64'h0);
      check("rst_rdata", 64'(cpu_if.cpu_rdata), 64'h0);
`ifdef SRAM_ARB_PERF_EN
      check("rst_conflict", 64'(conflict_cnt), 64'h0);
      check("rst_grant", 64'(grant_cnt), 64'h0);
`endif
      Reset = 1'b0;
      ptr_m = 0;
      exp_rdata = 16'h0;
   endtask

   // All ports in 'subset' raise req together from IDLE and each holds it until its ready.
   // Expected service order is the subset listed cyclically from the model pointer.
   task automatic run_round(input logic [3:0] subset, input string nm);
      int          order[$];
      int          n, k, ph, q;
      logic        w;
      logic [5:0]  exp_str;
      logic [3:0]  exp_rdy;
      for (int i = 0; i < 4; i++)
         if (subset[(ptr_m + i) % 4]) order.push_back((ptr_m + i) % 4);
      for (int i = 0; i < 4; i++) begin
         if (subset[i]) begin
            cpu_if.cpu_write[i] = t_write[i];
            cpu_if.cpu_addr[i]  = t_addr[i];
            cpu_if.cpu_wdata[i] = t_wdata[i];
         end
      end
      cpu_if.cpu_req = subset;
      n = order.size();
      for (int c = 1; c <= n * P + 2; c++) begin
         step();
         k  = (c - 1) / P;
         ph = (c - 1) % P;
         if (k >= 1 && ph == 0 && k <= n)
            cpu_if.cpu_req[order[k-1]] = 1'b0;
         exp_str = 6'b111110;
         exp_rdy = 4'b0000;
         if (k < n) begin
            q = order[k];
            w = t_write[q];
            if (ph == 0) begin
               exp_str = {3'b000, w, 1'b1, w};
            end else if (ph == P - 1) begin
               exp_str    = {3'b000, 1'b1, 1'b1, w};
               exp_rdy[q] = 1'b1;
               if (w) ref_mem[int'(t_addr[q])] = t_wdata[q];
               else   exp_rdata = ref_rd(t_addr[q]);
            end else begin
               exp_str = {3'b000, w, ~w, w};
            end
            check($sformatf("%s c%0d addr", nm, c), 64'(ADDR), 64'(t_addr[q]));
            if (w) check($sformatf("%s c%0d dout", nm, c), 64'(Data_out), 64'(t_wdata[q]));
         end
         check($sformatf("%s c%0d strobes", nm, c), 64'(strobes()), 64'(exp_str));
         check($sformatf("%s c%0d ready", nm, c), 64'(cpu_if.cpu_ready), 64'(exp_rdy));
         check($sformatf("%s c%0d rdata", nm, c), 64'(cpu_if.cpu_rdata), 64'(exp_rdata));
      end
      ptr_m = (order[n-1] + 1) % 4;
   endtask

   initial begin
      int  raise, grants, pos3;
      bit  seen3, seen1;

      Reset = 1'b1;
      cpu_if.cpu_req   = '0;
      cpu_if.cpu_write = '0;
      cpu_if.cpu_addr  = '0;
      cpu_if.cpu_wdata = '0;
      for (int i = 0; i < 4; i++) begin
         t_write[i] = 1'b0;
         t_addr[i]  = 20'h0;
         t_wdata[i] = 16'h0;
      end
      step();
      do_reset();
      step();
      check("idle_strobes", 64'(strobes()), 64'(6'b111110));

      // Single write then read-back on port 0
      t_write[0] = 1'b1; t_addr[0] = 20'h00010; t_wdata[0] = 16'h1234;
      run_round(4'b0001, "wr0");
      t_write[0] = 1'b0;
      run_round(4'b0001, "rd0");
      check("readback", 64'(cpu_if.cpu_rdata), 64'h1234);

      // Four simultaneous reads from reset: 0,1,2,3 back-to-back
      do_reset();
      for (int i = 0; i < 4; i++) begin
         t_write[i] = 1'b0;
         t_addr[i]  = 20'h00010 + 20'(i);
      end
      run_round(4'b1111, "all4");

      // Fairness: port1 holds req continuously, port3 asks once
      do_reset();
      cpu_if.cpu_write[1] = 1'b0; cpu_if.cpu_addr[1] = 20'h00011;
      cpu_if.cpu_write[3] = 1'b0; cpu_if.cpu_addr[3] = 20'h00013;
      cpu_if.cpu_req = 4'b0010;
      raise = $urandom_range(1, 8);
      for (int c = 0; c < raise; c++) step();
      cpu_if.cpu_req[3] = 1'b1;
      grants = 0; pos3 = 0; seen3 = 1'b0;
      for (int c = 0; c < 30 && !seen3; c++) begin
         step();
         if (cpu_if.cpu_ready != 4'b0000) grants++;
         if (cpu_if.cpu_ready[3]) begin
            seen3 = 1'b1;
            pos3  = grants;
         end
      end
      step();
      cpu_if.cpu_req[3] = 1'b0;
      check("fair_p3_within2", 64'(seen3 && pos3 >= 1 && pos3 <= 2), 64'h1);
      seen1 = 1'b0;
      for (int c = 0; c < 20 && !seen1; c++) begin
         step();
         if (cpu_if.cpu_ready[1]) seen1 = 1'b1;
      end
      step();
      cpu_if.cpu_req = '0;
      check("fair_p1_served", 64'(seen1), 64'h1);
      step();
      step();

      // Reset during the ACCESS cycle of a write
      do_reset();
      cpu_if.cpu_write[2] = 1'b1;
      cpu_if.cpu_addr[2]  = 20'hABCDE;
      cpu_if.cpu_wdata[2] = 16'hBEEF;
      cpu_if.cpu_req      = 4'b0100;
      step();
      step();
      check("mid_we_low", 64'(WE), 64'h0);
      Reset = 1'b1;
      step();
      check("mid_rst_strobes", 64'(strobes()), 64'(6'b111110));
      check("mid_rst_ready", 64'(cpu_if.cpu_ready), 64'h0);
      cpu_if.cpu_req = '0;
      Reset = 1'b0;
      ptr_m = 0;
      exp_rdata = 16'h0;
      step();
      check("mid_no_ready", 64'(cpu_if.cpu_ready), 64'h0);
      check("mid_idle", 64'(strobes()), 64'(6'b111110));
      // Pointer back at 0: port 0 must beat port 3
      t_write[0] = 1'b0; t_addr[0] = 20'h00010;
      t_write[3] = 1'b1; t_addr[3] = 20'h00015; t_wdata[3] = 16'h5A5A;
      run_round(4'b1001, "ptr0");

`ifdef SRAM_ARB_PERF_EN
      do_reset();
      for (int r = 0; r < 3; r++) begin
         t_write[0] = 1'b0; t_addr[0] = 20'h00012;
         t_write[2] = 1'b1; t_addr[2] = 20'h00014; t_wdata[2] = 16'(r + 7);
         run_round(4'b0101, "perf");
      end
      check("perf_conflict", 64'(conflict_cnt), 64'd3);
      check("perf_grant0", 64'(grant_cnt[0]), 64'd3);
      check("perf_grant2", 64'(grant_cnt[2]), 64'd3);
      check("perf_grant1", 64'(grant_cnt[1]), 64'd0);
`endif

      // Random rounds over a small address pool so reads hit earlier writes
      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < 4; i++) begin
            t_write[i] = 1'($urandom_range(0, 1));
            t_addr[i]  = 20'h00010 + 20'($urandom_range(0, 7));
            t_wdata[i] = 16'($urandom);
         end
         run_round(4'($urandom_range(1, 15)), $sformatf("rnd%0d", r));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
